// File: rtl/deint_chk_pkg.sv
// Shared constants and state encoding for the deinterleaver frame checker.
package deint_chk_pkg;

    localparam int unsigned FRAME_LEN = 280;
    localparam int unsigned DATA_W    = 12;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    function automatic logic [CNT_W-1:0] cnt_max(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/deint_frame_checker_stats.sv
// Per-frame error statistics: error total, current error run and longest run.
// Outputs are the registered values accumulated before the current symbol.
module frame_err_stats
    import deint_chk_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic             i_err,
    output logic [CNT_W-1:0] o_err_acc,
    output logic [CNT_W-1:0] o_cur_run,
    output logic [CNT_W-1:0] o_max_run
);

    logic [CNT_W-1:0] r_err_acc;
    logic [CNT_W-1:0] r_cur_run;
    logic [CNT_W-1:0] r_max_run;
    logic [CNT_W-1:0] w_run_upd;

    assign w_run_upd = i_err ? r_cur_run + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_err_acc <= '0;
            r_cur_run <= '0;
            r_max_run <= '0;
        end else if (i_valid) begin
            r_err_acc <= r_err_acc + CNT_W'(i_err);
            r_cur_run <= w_run_upd;
            r_max_run <= cnt_max(r_max_run, w_run_upd);
        end
    end

    assign o_err_acc = r_err_acc;
    assign o_cur_run = r_cur_run;
    assign o_max_run = r_max_run;

endmodule

// File: rtl/deint_frame_checker.sv
// Frame-alignment checker for the deinterleaved 1..FRAME_LEN symbol stream:
// acquires lock, flags per-symbol errors and reports per-frame error stats.
module deint_frame_checker
    import deint_chk_pkg::*;
#(
    parameter int unsigned CONFIRM_LEN = 8,
    parameter int unsigned LOSS_THRESH = 140,
    parameter int unsigned LOSS_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              lock,
    output logic              sym_err,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_err_count,
    output logic [CNT_W-1:0]  frame_max_burst,
    output logic [15:0]       frame_cnt
);

    localparam int unsigned CONF_W = $clog2(CONFIRM_LEN + 1);
    localparam int unsigned BAD_W  = $clog2(LOSS_FRAMES + 1);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_pos, w_pos_nxt;
    logic [CNT_W-1:0]  r_expected, w_expected_nxt;
    logic [CONF_W-1:0] r_confirm, w_confirm_nxt;
    logic [BAD_W-1:0]  r_bad, w_bad_nxt;
    logic              r_sym_err, w_sym_err_nxt;
    logic              r_frame_done, w_frame_done_nxt;
    logic [CNT_W-1:0]  r_fec, w_fec_nxt;
    logic [CNT_W-1:0]  r_fmb, w_fmb_nxt;
    logic [15:0]       r_fcnt, w_fcnt_nxt;

    logic              w_locked, w_last, w_err, w_din_one, w_din_exp;
    logic              w_stats_valid, w_stats_clear;
    logic [CNT_W-1:0]  w_exp_inc;
    logic [CONF_W-1:0] w_confirm_inc;
    logic [BAD_W-1:0]  w_bad_inc;
    logic [CNT_W-1:0]  w_err_acc, w_cur_run, w_max_run;
    logic [CNT_W-1:0]  w_final_acc, w_final_run, w_final_max;

    assign w_locked      = (r_state == LOCKED);
    assign w_last        = (r_pos == CNT_W'(FRAME_LEN));
    assign w_err         = (din != DATA_W'(r_pos));
    assign w_din_one     = (din == DATA_W'(1));
    assign w_din_exp     = (din == DATA_W'(r_expected));
    assign w_exp_inc     = (r_expected == CNT_W'(FRAME_LEN)) ? CNT_W'(1) : r_expected + 1'b1;
    assign w_confirm_inc = r_confirm + 1'b1;
    assign w_bad_inc     = r_bad + 1'b1;
    assign w_stats_valid = din_valid && w_locked;
    assign w_stats_clear = !w_locked || (w_stats_valid && w_last);

    frame_err_stats u_stats (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_stats_clear),
        .i_valid   (w_stats_valid),
        .i_err     (w_err),
        .o_err_acc (w_err_acc),
        .o_cur_run (w_cur_run),
        .o_max_run (w_max_run)
    );

    // Stats registers hold values before the last symbol; fold it in here.
    assign w_final_acc = w_err_acc + CNT_W'(w_err);
    assign w_final_run = w_err ? w_cur_run + 1'b1 : '0;
    assign w_final_max = cnt_max(w_max_run, w_final_run);

    always_comb begin
        w_state_nxt      = r_state;
        w_pos_nxt        = r_pos;
        w_expected_nxt   = r_expected;
        w_confirm_nxt    = r_confirm;
        w_bad_nxt        = r_bad;
        w_sym_err_nxt    = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_fec_nxt        = r_fec;
        w_fmb_nxt        = r_fmb;
        w_fcnt_nxt       = r_fcnt;
        if (din_valid) begin
            unique case (r_state)
                SEARCH: begin
                    if (w_din_one) begin
                        w_state_nxt    = VERIFY;
                        w_expected_nxt = CNT_W'(2);
                        w_confirm_nxt  = CONF_W'(1);
                    end
                end
                VERIFY: begin
                    if (w_din_exp) begin
                        w_expected_nxt = w_exp_inc;
                        w_confirm_nxt  = w_confirm_inc;
                        if (w_confirm_inc == CONF_W'(CONFIRM_LEN)) begin
                            w_state_nxt = LOCKED;
                            w_pos_nxt   = w_exp_inc;
                            w_bad_nxt   = '0;
                        end
                    end else if (w_din_one) begin
                        w_expected_nxt = CNT_W'(2);
                        w_confirm_nxt  = CONF_W'(1);
                    end else begin
                        w_state_nxt = SEARCH;
                    end
                end
                LOCKED: begin
                    w_sym_err_nxt = w_err;
                    if (w_last) begin
                        w_frame_done_nxt = 1'b1;
                        w_fec_nxt        = w_final_acc;
                        w_fmb_nxt        = w_final_max;
                        w_fcnt_nxt       = r_fcnt + 1'b1;
                        w_pos_nxt        = CNT_W'(1);
                        if (w_final_acc >= CNT_W'(LOSS_THRESH)) begin
                            w_bad_nxt = w_bad_inc;
                            if (w_bad_inc == BAD_W'(LOSS_FRAMES)) begin
                                w_state_nxt = SEARCH;
                            end
                        end else begin
                            w_bad_nxt = '0;
                        end
                    end else begin
                        w_pos_nxt = r_pos + 1'b1;
                    end
                end
                default: w_state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SEARCH;
            r_pos        <= '0;
            r_expected   <= '0;
            r_confirm    <= '0;
            r_bad        <= '0;
            r_sym_err    <= 1'b0;
            r_frame_done <= 1'b0;
            r_fec        <= '0;
            r_fmb        <= '0;
            r_fcnt       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pos        <= w_pos_nxt;
            r_expected   <= w_expected_nxt;
            r_confirm    <= w_confirm_nxt;
            r_bad        <= w_bad_nxt;
            r_sym_err    <= w_sym_err_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_fec        <= w_fec_nxt;
            r_fmb        <= w_fmb_nxt;
            r_fcnt       <= w_fcnt_nxt;
        end
    end

    assign lock            = w_locked;
    assign sym_err         = r_sym_err;
    assign frame_done      = r_frame_done;
    assign frame_err_count = r_fec;
    assign frame_max_burst = r_fmb;
    assign frame_cnt       = r_fcnt;

endmodule

// File: doc/deint_frame_checker.md
Name: deint_frame_checker

Overview:
- Sits directly downstream of the deinterleaver RAM and consumes its 12-bit symbol stream. This replaces the memoryless error_check threshold.
- Acquires frame alignment on the 280-symbol sequence 1..280 and compares every symbol against its expected position value.
- Reports per-symbol errors and, once per frame, the error count and the longest run of consecutive errors. The longest run shows how well the interleaver spread a channel burst.

Parameters:
- FRAME_LEN, 280: symbols per frame; valid values are 1..FRAME_LEN.
- DATA_W, 12: symbol width.
- CONFIRM_LEN, 8: consecutive correct symbols, counting the initial 1, required to declare lock.
- LOSS_THRESH, 140: errors per frame at or above which the frame counts as bad.
- LOSS_FRAMES, 2: consecutive bad frames that cause loss of lock.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- din_valid, input, 1: din carries a symbol this cycle.
- din, input, DATA_W: deinterleaved symbol.
- lock, output, 1: high in the LOCKED state.
- sym_err, output, 1: registered; the previous valid symbol mismatched its position (LOCKED only).
- frame_done, output, 1: one-cycle pulse after the last symbol of a frame.
- frame_err_count, output, 9: errors in the completed frame; held between pulses.
- frame_max_burst, output, 9: longest error run in the completed frame; held between pulses.
- frame_cnt, output, 16: completed frames while locked; wraps at 2^16.

Behaviour:
- Reset: synchronous, active-high. Every output is 0. State is SEARCH. Position, run and error counters are cleared. A reset mid-frame discards the partial frame; no frame_done is produced for it.
- Cycles with din_valid=0 are bubbles: no state, position, counter or burst change. sym_err and frame_done are 0 on the following cycle.
- SEARCH:
  - On a valid din==1, go to VERIFY with expected=2 and confirm_run=1.
  - Otherwise stay in SEARCH. sym_err stays 0.
- VERIFY:
  - On a valid din==expected, increment expected and confirm_run.
  - When confirm_run reaches CONFIRM_LEN, go to LOCKED with position=expected. Per-frame counters start at 0; the confirmed symbols are error-free.
  - On a valid mismatch: if din==1, restart VERIFY (expected=2, confirm_run=1); otherwise go to SEARCH.
  - expected wraps FRAME_LEN->1.
- LOCKED, position p in 1..FRAME_LEN, on each valid symbol:
  - err = (din != p). A corrupted value above FRAME_LEN is simply a mismatch.
  - sym_err <= err, one cycle of latency.
  - If err: err_acc increments and cur_run increments. Otherwise cur_run resets to 0.
  - max_run takes the maximum of itself and the updated cur_run in the same cycle.
  - If p==FRAME_LEN, on the next cycle:
    - frame_done=1.
    - frame_err_count and frame_max_burst load the final values, including this symbol.
    - frame_cnt increments.
    - err_acc, cur_run and max_run clear. Bursts never span frames.
    - p wraps to 1.
  - Otherwise p increments.
  - Bad-frame tracking, evaluated at frame end:
    - If the final err_acc >= LOSS_THRESH, bad_frames increments; otherwise bad_frames clears.
    - If bad_frames reaches LOSS_FRAMES, go to SEARCH and lock falls with the same edge that raises frame_done.
- Position never resynchronises while LOCKED. A slipped stream shows as continuous errors until lock is lost.
- Widths:
  - Counters are 9-bit, with maximum value FRAME_LEN. No saturation logic is needed.
  - Comparisons are unsigned, and p is zero-extended to DATA_W.

Decomposition:
- Package deint_chk_pkg holds:
  - FRAME_LEN and DATA_W constants.
  - The state enum (SEARCH, VERIFY, LOCKED).
  - A count width derived as clog2(FRAME_LEN+1).
- Sub-module frame_err_stats handles the per-frame statistics:
  - Inputs: clk, rst, clear, valid and err.
  - Outputs: err_acc, cur_run and max_run.
- The top level keeps the FSM, the position counter, the bad-frame counter and the output registers.

Test Plan:
- Clean stream 1..280 repeated, from reset:
  - lock rises on the cycle after the 8th valid symbol (value 8).
  - The first frame_done follows symbol 280 with err_count=0 and max_burst=0.
  - frame_cnt=1, then increments each frame.
- Stream starting at 137, clean:
  - lock stays 0 through value 280.
  - Lock follows symbols 1..8 of the next frame.
  - sym_err stays 0 throughout.
- Locked; din=p+300 for positions 50..59:
  - sym_err is high for exactly 10 cycles.
  - frame_err_count=10, frame_max_burst=10; the next frame reports 0/0.
- Locked; errors at positions 3, 10 and 17 only, with random din_valid bubbles inserted throughout:
  - frame_err_count=3, frame_max_burst=1, and lock is retained.
- Locked; two consecutive frames with 150 errors each:
  - lock falls with the second frame_done, which reports 150.
  - After a clean frame-aligned restart, lock is reacquired.
- Locked; rst asserted for one cycle at position 120:
  - All outputs are 0 on the next cycle, and no frame_done occurs for the partial frame.
  - Reacquisition proceeds as in the clean-stream case.
